wr_arria10_xcvr_reset_ctrl: RTL and testbench
=============================================

WR_ARRIA10_XCVR_RESET_CTRL -- requirements
Module: wr_arria10_xcvr_reset_ctrl

Interface
REQ-001 SHALL have parameter g_NUM_CHANNELS, default 1, number of transceiver channels (1..16).
REQ-002 SHALL have parameter g_T_PLL_PD, default 1000, cycles pll_powerdown_o is held after a TX reset start (>=1).
REQ-003 SHALL have parameter g_T_TX_DIG, default 20, cycles between tx_analogreset_o and tx_digitalreset_o release (>=1).
REQ-004 SHALL have parameter g_T_RX_ANA, default 1000, minimum cycles rx_analogreset_o is held (>=1).
REQ-005 SHALL have parameter g_T_LTD, default 4000, cycles rx_is_lockedtodata_i must be stable high before RX digital release (>=1).
REQ-006 SHALL have ports: clk_i in 1 system clock; rst_i in 1 asynchronous active-high reset; pll_locked_i in 1 TX PLL lock; pll_powerdown_o out 1 TX PLL powerdown; tx_reset_req_i in 1 TX restart pulse; tx_cal_busy_i in N; tx_analogreset_o out N; tx_digitalreset_o out N; tx_ready_o out N; rx_reset_req_i in N per-channel RX restart pulse; rx_cal_busy_i in N; rx_is_lockedtodata_i in N; rx_analogreset_o out N; rx_digitalreset_o out N; rx_ready_o out N (N = g_NUM_CHANNELS).

Function
REQ-007 SHALL pass pll_locked_i, tx_cal_busy_i, rx_cal_busy_i, rx_is_lockedtodata_i through 2-FF synchronizers; all decisions use synchronized values (2-cycle input latency).
REQ-008 SHALL implement one shared TX FSM: T_PLL_PD, T_WAIT_LOCK, T_ANA_REL, T_READY.
REQ-009 T_PLL_PD: pll_powerdown_o=1, all tx resets=1, tx_ready_o=0; after g_T_PLL_PD cycles -> T_WAIT_LOCK.
REQ-010 T_WAIT_LOCK: pll_powerdown_o=0; -> T_ANA_REL when pll_locked high and all tx_cal_busy low in the same cycle; otherwise hold.
REQ-011 T_ANA_REL: tx_analogreset_o=0, tx_digitalreset_o=1; after g_T_TX_DIG cycles -> T_READY; pll_locked low during count -> T_WAIT_LOCK (analog reset stays released).
REQ-012 T_READY: tx_digitalreset_o=0, tx_ready_o all 1; pll_locked low -> T_WAIT_LOCK with tx_digitalreset_o=1, tx_ready_o=0 next cycle.
REQ-013 tx_reset_req_i high in any TX state SHALL force T_PLL_PD next cycle and restart its counter; it has priority over lock loss.
REQ-014 SHALL implement one independent RX FSM per channel: R_ANA, R_WAIT_LTD, R_LTD_STABLE, R_READY.
REQ-015 R_ANA: rx_analogreset=1, rx_digitalreset=1, rx_ready=0; counter runs only while rx_cal_busy low (cal_busy high holds counter); after g_T_RX_ANA counted cycles -> R_WAIT_LTD.
REQ-016 R_WAIT_LTD: rx_analogreset=0, rx_digitalreset=1; lockedtodata high -> R_LTD_STABLE with counter cleared.
REQ-017 R_LTD_STABLE: lockedtodata low -> R_WAIT_LTD; after g_T_LTD consecutive high cycles -> R_READY.
REQ-018 R_READY: rx_digitalreset=0, rx_ready=1; lockedtodata low -> R_WAIT_LTD (digital reset reasserted, analog unchanged).
REQ-019 rx_reset_req_i[n] high SHALL force channel n to R_ANA next cycle, priority over all other transitions; other channels unaffected.
REQ-020 Counters SHALL be sized ceil(log2(max parameter+1)) bits, saturate-free (cleared on every state entry), never wrap.
REQ-021 All outputs SHALL be registered; state change and output change occur on the same clock edge.
REQ-022 TX and RX FSMs SHALL be mutually independent; RX does not wait for TX readiness.

Reset
REQ-023 rst_i high SHALL asynchronously set: pll_powerdown_o=1, all tx/rx analog and digital resets=1, all ready=0, TX FSM=T_PLL_PD, RX FSMs=R_ANA, counters=0, synchronizers=0.
REQ-024 Release of rst_i SHALL be assumed synchronous to clk_i externally; sequencing starts on the first edge after release.
REQ-025 rst_i asserted mid-sequence SHALL abort all FSMs immediately to reset values.

Verification (N=2, g_T_PLL_PD=4, g_T_TX_DIG=3, g_T_RX_ANA=5, g_T_LTD=8)
REQ-026 Reset release, pll_locked=1, cal_busy=0 -> pll_powerdown_o low after 4 cycles; tx_analogreset low at lock+2 sync; tx_digitalreset low and tx_ready=2'b11 3 cycles later.
REQ-027 Channel 0 lockedtodata high from start, cal_busy low -> rx_analogreset[0] low after 5 cycles; rx_digitalreset[0] low, rx_ready[0]=1 after 8 further stable cycles.
REQ-028 lockedtodata[1] glitches low for 1 cycle at stable count 6 -> channel 1 returns to R_WAIT_LTD, count restarts, ready delayed by full 8 cycles; channel 0 unaffected.
REQ-029 In T_READY drop pll_locked for 10 cycles -> tx_digitalreset=11, tx_ready=00, pll_powerdown stays 0; relock -> ready again 3 cycles after synchronized lock.
REQ-030 rx_cal_busy[0] high for 7 cycles during R_ANA -> rx_analogreset[0] held 5 counted cycles plus 7 stalled cycles.
REQ-031 tx_reset_req_i and pll_locked drop in the same cycle in T_READY -> next state T_PLL_PD, pll_powerdown_o=1 for 4 cycles; rst_i pulse mid-sequence -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/wr_arria10_xcvr_reset_ctrl.sv
// Arria 10 transceiver reset sequencer: one shared TX PLL/analog/digital sequence
// and an independent RX analog/lock-to-data/digital sequence per channel.
module wr_arria10_xcvr_reset_ctrl #(
  parameter int unsigned g_NUM_CHANNELS = 1,
  parameter int unsigned g_T_PLL_PD     = 1000,
  parameter int unsigned g_T_TX_DIG     = 20,
  parameter int unsigned g_T_RX_ANA     = 1000,
  parameter int unsigned g_T_LTD        = 4000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      pll_locked_i,
  output logic                      pll_powerdown_o,
  input  logic                      tx_reset_req_i,
  input  logic [g_NUM_CHANNELS-1:0] tx_cal_busy_i,
  output logic [g_NUM_CHANNELS-1:0] tx_analogreset_o,
  output logic [g_NUM_CHANNELS-1:0] tx_digitalreset_o,
  output logic [g_NUM_CHANNELS-1:0] tx_ready_o,
  input  logic [g_NUM_CHANNELS-1:0] rx_reset_req_i,
  input  logic [g_NUM_CHANNELS-1:0] rx_cal_busy_i,
  input  logic [g_NUM_CHANNELS-1:0] rx_is_lockedtodata_i,
  output logic [g_NUM_CHANNELS-1:0] rx_analogreset_o,
  output logic [g_NUM_CHANNELS-1:0] rx_digitalreset_o,
  output logic [g_NUM_CHANNELS-1:0] rx_ready_o
);

  localparam int unsigned N      = g_NUM_CHANNELS;
  localparam int unsigned SW     = 1 + 3 * N;
  localparam int unsigned TX_MAX = (g_T_PLL_PD > g_T_TX_DIG) ? g_T_PLL_PD : g_T_TX_DIG;
  localparam int unsigned RX_MAX = (g_T_RX_ANA > g_T_LTD) ? g_T_RX_ANA : g_T_LTD;
  localparam int unsigned TX_CW  = $clog2(TX_MAX + 1);
  localparam int unsigned RX_CW  = $clog2(RX_MAX + 1);

  localparam logic [TX_CW-1:0] TX_PD_LAST  = TX_CW'(g_T_PLL_PD - 1);
  localparam logic [TX_CW-1:0] TX_DIG_LAST = TX_CW'(g_T_TX_DIG - 1);
  localparam logic [RX_CW-1:0] RX_ANA_LAST = RX_CW'(g_T_RX_ANA - 1);
  localparam logic [RX_CW-1:0] RX_LTD_LAST = RX_CW'(g_T_LTD - 1);

  localparam logic [1:0] T_PLL_PD    = 2'd0;
  localparam logic [1:0] T_WAIT_LOCK = 2'd1;
  localparam logic [1:0] T_ANA_REL   = 2'd2;
  localparam logic [1:0] T_READY     = 2'd3;

  localparam logic [1:0] R_ANA        = 2'd0;
  localparam logic [1:0] R_WAIT_LTD   = 2'd1;
  localparam logic [1:0] R_LTD_STABLE = 2'd2;
  localparam logic [1:0] R_READY      = 2'd3;

  // Two-stage synchronizer for all asynchronous status inputs
  logic [SW-1:0] sync_meta_q, sync_meta_d, sync_q, sync_d;
  logic          lock_s;
  logic [N-1:0]  tx_busy_s, rx_busy_s, ltd_s;

  always_comb begin
    sync_meta_d = {pll_locked_i, tx_cal_busy_i, rx_cal_busy_i, rx_is_lockedtodata_i};
    sync_d      = sync_meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
    end
  end

  assign lock_s    = sync_q[SW-1];
  assign tx_busy_s = sync_q[3*N-1 -: N];
  assign rx_busy_s = sync_q[2*N-1 -: N];
  assign ltd_s     = sync_q[N-1:0];

  // Shared TX sequence
  logic [1:0]       tx_state_q, tx_state_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic             pll_pd_q, pll_pd_d;
  logic [N-1:0]     tx_ana_q, tx_ana_d, tx_dig_q, tx_dig_d, tx_rdy_q, tx_rdy_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    if (tx_reset_req_i) begin
      tx_state_d = T_PLL_PD;
      tx_cnt_d   = '0;
    end else begin
      case (tx_state_q)
        T_PLL_PD: begin
          if (tx_cnt_q == TX_PD_LAST) begin
            tx_state_d = T_WAIT_LOCK;
            tx_cnt_d   = '0;
          end else begin
            tx_cnt_d = tx_cnt_q + TX_CW'(1);
          end
        end
        T_WAIT_LOCK: begin
          if (lock_s && !(|tx_busy_s)) begin
            tx_state_d = T_ANA_REL;
            tx_cnt_d   = '0;
          end
        end
        T_ANA_REL: begin
          if (!lock_s) begin
            tx_state_d = T_WAIT_LOCK;
            tx_cnt_d   = '0;
          end else if (tx_cnt_q == TX_DIG_LAST) begin
            tx_state_d = T_READY;
            tx_cnt_d   = '0;
          end else begin
            tx_cnt_d = tx_cnt_q + TX_CW'(1);
          end
        end
        T_READY: begin
          if (!lock_s) begin
            tx_state_d = T_WAIT_LOCK;
            tx_cnt_d   = '0;
          end
        end
        default: begin
          tx_state_d = T_PLL_PD;
          tx_cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the next state so they switch on the same edge as the FSM
    pll_pd_d = (tx_state_d == T_PLL_PD);
    tx_ana_d = tx_ana_q;
    if (tx_state_d == T_PLL_PD) begin
      tx_ana_d = '1;
    end else if (tx_state_d != T_WAIT_LOCK) begin
      tx_ana_d = '0;
    end
    tx_dig_d = (tx_state_d == T_READY) ? '0 : '1;
    tx_rdy_d = (tx_state_d == T_READY) ? '1 : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= T_PLL_PD;
      tx_cnt_q   <= '0;
      pll_pd_q   <= 1'b1;
      tx_ana_q   <= '1;
      tx_dig_q   <= '1;
      tx_rdy_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      pll_pd_q   <= pll_pd_d;
      tx_ana_q   <= tx_ana_d;
      tx_dig_q   <= tx_dig_d;
      tx_rdy_q   <= tx_rdy_d;
    end
  end

  assign pll_powerdown_o   = pll_pd_q;
  assign tx_analogreset_o  = tx_ana_q;
  assign tx_digitalreset_o = tx_dig_q;
  assign tx_ready_o        = tx_rdy_q;

  // Independent RX sequence per channel
  for (genvar n = 0; n < N; n++) begin : g_rx
    logic [1:0]       state_q, state_d;
    logic [RX_CW-1:0] cnt_q, cnt_d;
    logic             ana_q, ana_d, dig_q, dig_d, rdy_q, rdy_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (rx_reset_req_i[n]) begin
        state_d = R_ANA;
        cnt_d   = '0;
      end else begin
        case (state_q)
          R_ANA: begin
            if (!rx_busy_s[n]) begin
              if (cnt_q == RX_ANA_LAST) begin
                state_d = R_WAIT_LTD;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + RX_CW'(1);
              end
            end
          end
          R_WAIT_LTD: begin
            if (ltd_s[n]) begin
              state_d = R_LTD_STABLE;
              cnt_d   = '0;
            end
          end
          R_LTD_STABLE: begin
            if (!ltd_s[n]) begin
              state_d = R_WAIT_LTD;
              cnt_d   = '0;
            end else if (cnt_q == RX_LTD_LAST) begin
              state_d = R_READY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + RX_CW'(1);
            end
          end
          R_READY: begin
            if (!ltd_s[n]) begin
              state_d = R_WAIT_LTD;
              cnt_d   = '0;
            end
          end
          default: begin
            state_d = R_ANA;
            cnt_d   = '0;
          end
        endcase
      end
      ana_d = (state_d == R_ANA);
      dig_d = (state_d != R_READY);
      rdy_d = (state_d == R_READY);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= R_ANA;
        cnt_q   <= '0;
        ana_q   <= 1'b1;
        dig_q   <= 1'b1;
        rdy_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ana_q   <= ana_d;
        dig_q   <= dig_d;
        rdy_q   <= rdy_d;
      end
    end

    assign rx_analogreset_o[n]  = ana_q;
    assign rx_digitalreset_o[n] = dig_q;
    assign rx_ready_o[n]        = rdy_q;
  end

endmodule

// File: tb/tb_wr_arria10_xcvr_reset_ctrl.sv
// Scoreboard bench for the transceiver reset sequencer: a timeline model predicts
// every cycle's outputs, a negedge monitor compares them against the DUT.
module tb_wr_arria10_xcvr_reset_ctrl;

  localparam int unsigned N = 2;
  localparam int P = 4;
  localparam int D = 3;
  localparam int A = 5;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         pll_locked_i, pll_powerdown_o, tx_reset_req_i;
  logic [N-1:0] tx_cal_busy_i, tx_analogreset_o, tx_digitalreset_o, tx_ready_o;
  logic [N-1:0] rx_reset_req_i, rx_cal_busy_i, rx_is_lockedtodata_i;
  logic [N-1:0] rx_analogreset_o, rx_digitalreset_o, rx_ready_o;

  always #5 clk = ~clk;

  wr_arria10_xcvr_reset_ctrl #(
    .g_NUM_CHANNELS(N), .g_T_PLL_PD(P), .g_T_TX_DIG(D), .g_T_RX_ANA(A), .g_T_LTD(L)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .pll_locked_i(pll_locked_i), .pll_powerdown_o(pll_powerdown_o),
    .tx_reset_req_i(tx_reset_req_i), .tx_cal_busy_i(tx_cal_busy_i),
    .tx_analogreset_o(tx_analogreset_o), .tx_digitalreset_o(tx_digitalreset_o),
    .tx_ready_o(tx_ready_o),
    .rx_reset_req_i(rx_reset_req_i), .rx_cal_busy_i(rx_cal_busy_i),
    .rx_is_lockedtodata_i(rx_is_lockedtodata_i),
    .rx_analogreset_o(rx_analogreset_o), .rx_digitalreset_o(rx_digitalreset_o),
    .rx_ready_o(rx_ready_o)
  );

  typedef struct packed {
    logic         pd;
    logic [N-1:0] ta, td, tr, ra, rd, rr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pushed = 0;

  // Model: elapsed-time bookkeeping per sequence plus a 2-deep input delay line
  int           pd_el, tx_run, rx_el[N], rx_run[N];
  bit           tx_armed, tx_ana_rel, rx_seen[N];
  logic         lock_h1, lock_h2;
  logic [N-1:0] txb_h1, txb_h2, rxb_h1, rxb_h2, ltd_h1, ltd_h2;

  function automatic void model_reset();
    pd_el = 0; tx_run = 0; tx_armed = 0; tx_ana_rel = 0;
    for (int c = 0; c < N; c++) begin
      rx_el[c] = 0; rx_run[c] = 0; rx_seen[c] = 0;
    end
    lock_h1 = 0; lock_h2 = 0;
    txb_h1 = '0; txb_h2 = '0; rxb_h1 = '0; rxb_h2 = '0; ltd_h1 = '0; ltd_h2 = '0;
  endfunction

  function automatic void model_step();
    logic         lk;
    logic [N-1:0] mtb, mrb, mld;
    lk = lock_h2; mtb = txb_h2; mrb = rxb_h2; mld = ltd_h2;
    lock_h2 = lock_h1; lock_h1 = pll_locked_i;
    txb_h2 = txb_h1; txb_h1 = tx_cal_busy_i;
    rxb_h2 = rxb_h1; rxb_h1 = rx_cal_busy_i;
    ltd_h2 = ltd_h1; ltd_h1 = rx_is_lockedtodata_i;

    if (tx_reset_req_i) begin
      pd_el = 0; tx_armed = 0; tx_run = 0; tx_ana_rel = 0;
    end else if (pd_el < P) begin
      pd_el++;
    end else if (!tx_armed) begin
      if (lk && !(|mtb)) begin
        tx_armed = 1; tx_run = 0; tx_ana_rel = 1;
      end
    end else if (!lk) begin
      tx_armed = 0;
    end else if (tx_run < D) begin
      tx_run++;
    end

    for (int c = 0; c < N; c++) begin
      if (rx_reset_req_i[c]) begin
        rx_el[c] = 0; rx_seen[c] = 0; rx_run[c] = 0;
      end else if (rx_el[c] < A) begin
        if (!mrb[c]) rx_el[c]++;
      end else if (!mld[c]) begin
        rx_seen[c] = 0; rx_run[c] = 0;
      end else if (!rx_seen[c]) begin
        rx_seen[c] = 1; rx_run[c] = 0;
      end else if (rx_run[c] < L) begin
        rx_run[c]++;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic rdy;
    rdy  = tx_armed && (tx_run >= D);
    e.pd = (pd_el < P);
    e.ta = tx_ana_rel ? '0 : '1;
    e.td = rdy ? '0 : '1;
    e.tr = rdy ? '1 : '0;
    for (int c = 0; c < N; c++) begin
      e.ra[c] = (rx_el[c] < A);
      e.rr[c] = rx_seen[c] && (rx_run[c] >= L);
      e.rd[c] = !e.rr[c];
    end
    return e;
  endfunction

  // One clock: account for the edge just taken, then drive the next inputs
  task automatic tick(input logic lk, input logic [N-1:0] txb, input logic [N-1:0] rxb,
                      input logic [N-1:0] ltd, input logic txr, input logic [N-1:0] rxr,
                      input logic rst_v);
    @(posedge clk);
    #1;
    if (rst_i) model_reset();
    else model_step();
    pll_locked_i = lk; tx_cal_busy_i = txb; rx_cal_busy_i = rxb;
    rx_is_lockedtodata_i = ltd; tx_reset_req_i = txr; rx_reset_req_i = rxr;
    rst_i = rst_v;
    if (rst_v) model_reset();
    exp_q.push_back(model_out());
    pushed++;
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pll_powerdown_o, tx_analogreset_o, tx_digitalreset_o, tx_ready_o,
           rx_analogreset_o, rx_digitalreset_o, rx_ready_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t got pd=%b ta=%b td=%b tr=%b ra=%b rd=%b rr=%b expected pd=%b ta=%b td=%b tr=%b ra=%b rd=%b rr=%b",
                 $time, a.pd, a.ta, a.td, a.tr, a.ra, a.rd, a.rr,
                 e.pd, e.ta, e.td, e.tr, e.ra, e.rd, e.rr);
      end
    end
  end

  initial begin
    logic         lk, txr, rst_v;
    logic [N-1:0] txb, rxb, ltd, rxr;
    int           rst_hold;

    rst_i = 1'b1; pll_locked_i = 1'b0; tx_reset_req_i = 1'b0;
    tx_cal_busy_i = '0; rx_reset_req_i = '0; rx_cal_busy_i = '0; rx_is_lockedtodata_i = '0;
    model_reset();

    for (int i = 0; i < 3; i++) tick(1'b1, '0, '0, 2'b11, 1'b0, '0, 1'b1);
    // Clean bring-up; channel 1 lock-to-data glitches once mid stable count
    for (int i = 0; i < 40; i++) tick(1'b1, '0, '0, (i == 12) ? 2'b01 : 2'b11, 1'b0, '0, 1'b0);
    // PLL lock loss in ready, then relock
    for (int i = 0; i < 10; i++) tick(1'b0, '0, '0, 2'b11, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, '0, '0, 2'b11, 1'b0, '0, 1'b0);
    // RX restart on channel 0 with calibration stalling the analog count
    tick(1'b1, '0, '0, 2'b11, 1'b0, 2'b01, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b1, '0, 2'b01, 2'b11, 1'b0, '0, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b1, '0, '0, 2'b11, 1'b0, '0, 1'b0);
    // TX restart together with lock loss, then an asynchronous reset mid-sequence
    tick(1'b0, '0, '0, 2'b11, 1'b1, '0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, '0, '0, 2'b11, 1'b0, '0, 1'b0);
    tick(1'b1, '0, '0, 2'b11, 1'b0, '0, 1'b1);
    for (int i = 0; i < 30; i++) tick(1'b1, '0, '0, 2'b11, 1'b0, '0, 1'b0);

    lk = 1'b1; txb = '0; rxb = '0; ltd = 2'b11; rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) lk = ~lk;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 99) < (txb[c] ? 25 : 2)) txb[c] = ~txb[c];
        if ($urandom_range(0, 99) < (rxb[c] ? 25 : 3)) rxb[c] = ~rxb[c];
        if ($urandom_range(0, 99) < 3) ltd[c] = ~ltd[c];
        rxr[c] = ($urandom_range(0, 99) < 1);
      end
      txr = ($urandom_range(0, 99) < 1);
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 999) < 2) rst_hold = $urandom_range(1, 2);
      rst_v = (rst_hold > 0);
      tick(lk, txb, rxb, ltd, txr, rxr, rst_v);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0 || vectors != pushed) begin
      miscompares++;
      $display("FAIL drain got %0d checked, required %0d", vectors, pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
